// File: rtl/fg_pkg.sv
// Shared definitions for the FG sweep generator: waveform mode codes, noise LFSR
// constants and helpers used by the top level and the wave shaper.
package fg_pkg;

    localparam logic [2:0] FG_MODE_CONST  = 3'd0;
    localparam logic [2:0] FG_MODE_SAW    = 3'd1;
    localparam logic [2:0] FG_MODE_TRI    = 3'd2;
    localparam logic [2:0] FG_MODE_SQUARE = 3'd3;
    localparam logic [2:0] FG_MODE_NOISE  = 3'd4;

    typedef logic [2:0] fg_mode_t;

    localparam int unsigned FG_LFSR_W    = 16;
    localparam logic [15:0] FG_LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shifting form: feedback from bits 0, 2, 3, 5
    localparam logic [15:0] FG_LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] fg_lfsr_next(input logic [15:0] state);
        return {^(state & FG_LFSR_TAPS), state[15:1]};
    endfunction

    function automatic int fg_saturate(input int value, input int unsigned width);
        int max_v;
        int min_v;
        max_v = (1 << (width - 1)) - 1;
        min_v = -(1 << (width - 1));
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/fg_wave_shaper.sv
// Combinational wave shaper: maps the phase MSBs, noise bits, duty threshold and
// mode to an unsigned raw wave sample.
module fg_wave_shaper
    import fg_pkg::*;
#(
    parameter int unsigned OUT_W = 8
) (
    input  fg_mode_t         mode_i,
    input  logic [OUT_W:0]   phase_top_i,
    input  logic [OUT_W-1:0] noise_i,
    input  logic [OUT_W-1:0] duty_i,
    output logic [OUT_W-1:0] wave_o
);

    logic [OUT_W-1:0] w_saw;
    logic [OUT_W-1:0] w_tri;
    logic [OUT_W-1:0] w_sq;

    // phase_top_i carries the OUT_W+1 most significant phase bits
    assign w_saw = phase_top_i[OUT_W:1];
    assign w_tri = phase_top_i[OUT_W] ? ~phase_top_i[OUT_W-1:0] : phase_top_i[OUT_W-1:0];
    assign w_sq  = (w_saw < duty_i) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    always_comb begin
        wave_o = '0;
        case (mode_i)
            FG_MODE_SAW:    wave_o = w_saw;
            FG_MODE_TRI:    wave_o = w_tri;
            FG_MODE_SQUARE: wave_o = w_sq;
            FG_MODE_NOISE:  wave_o = noise_i;
            default:        wave_o = '0;
        endcase
    end

endmodule

// File: rtl/fg_sweep_generator.sv
// Phase-accumulator function generator with shadowed configuration applied at period
// wrap, linear frequency sweep, prescaler and a saturating gain/offset output stage.
module fg_sweep_generator
    import fg_pkg::*;
#(
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned PSC_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [2:0]         cfg_mode_i,
    input  logic [PSC_W-1:0]   cfg_psc_i,
    input  logic [PHASE_W-1:0] cfg_start_i,
    input  logic [PHASE_W-1:0] cfg_stop_i,
    input  logic [PHASE_W-1:0] cfg_inc_i,
    input  logic [OUT_W-1:0]   cfg_duty_i,
    input  logic [OUT_W-1:0]   cfg_amp_i,
    input  logic [OUT_W-1:0]   cfg_offset_i,
    output logic [OUT_W-1:0]   out_o,
    output logic               out_valid_o,
    output logic               sweep_done_o
);

    // Shadow configuration, loaded on accept
    logic               r_pending;
    fg_mode_t           r_sh_mode;
    logic [PSC_W-1:0]   r_sh_psc;
    logic [PHASE_W-1:0] r_sh_start;
    logic [PHASE_W-1:0] r_sh_stop;
    logic [PHASE_W-1:0] r_sh_inc;
    logic [OUT_W-1:0]   r_sh_duty;
    logic [OUT_W-1:0]   r_sh_amp;
    logic [OUT_W-1:0]   r_sh_offset;

    // Active configuration
    fg_mode_t           r_mode;
    logic [PSC_W-1:0]   r_psc;
    logic [PHASE_W-1:0] r_start;
    logic [PHASE_W-1:0] r_stop;
    logic [PHASE_W-1:0] r_inc;
    logic [OUT_W-1:0]   r_duty;
    logic [OUT_W-1:0]   r_amp;
    logic [OUT_W-1:0]   r_offset;

    logic [PSC_W-1:0]     r_psc_cnt;
    logic [PHASE_W-1:0]   r_phase;
    logic [PHASE_W-1:0]   r_step;
    logic [FG_LFSR_W-1:0] r_lfsr;
    logic                 r_tick_d;
    logic [OUT_W-1:0]     r_out;
    logic                 r_out_valid;
    logic                 r_done;

    logic               w_accept;
    logic               w_tick;
    logic [PHASE_W:0]   w_phase_sum;
    logic               w_wrap;
    logic               w_apply;
    logic [PHASE_W:0]   w_step_inc;
    logic [PHASE_W-1:0] w_step_swept;

    assign w_accept    = cfg_valid_i & ~r_pending;
    assign w_tick      = enable_i & (r_psc_cnt == r_psc);
    assign w_phase_sum = {1'b0, r_phase} + {1'b0, r_step};
    assign w_wrap      = w_tick & w_phase_sum[PHASE_W];
    // While disabled a pending config goes live at once; while running only at a wrap
    assign w_apply     = r_pending & (~enable_i | w_wrap);
    assign w_step_inc  = {1'b0, r_step} + {1'b0, r_inc};
    assign w_step_swept = (w_step_inc > {1'b0, r_stop}) ? r_stop : w_step_inc[PHASE_W-1:0];

    // Output stage, evaluated the cycle after a tick on the updated phase
    logic [OUT_W-1:0]          w_wave;
    logic signed [OUT_W-1:0]   w_ws;
    logic signed [2*OUT_W:0]   w_ws_ext;
    logic signed [2*OUT_W:0]   w_amp_ext;
    logic signed [2*OUT_W:0]   w_prod;
    logic signed [2*OUT_W:0]   w_sc;
    logic                      w_is_const;
    int                        w_sum;
    int                        w_sat;

    fg_wave_shaper #(
        .OUT_W (OUT_W)
    ) u_wave_shaper (
        .mode_i      (r_mode),
        .phase_top_i (r_phase[PHASE_W-1 -: OUT_W+1]),
        .noise_i     (r_lfsr[OUT_W-1:0]),
        .duty_i      (r_duty),
        .wave_o      (w_wave)
    );

    // Subtracting half scale from an unsigned value is an MSB flip in two's complement
    assign w_ws       = {~w_wave[OUT_W-1], w_wave[OUT_W-2:0]};
    assign w_ws_ext   = {{(OUT_W+1){w_ws[OUT_W-1]}}, w_ws};
    assign w_amp_ext  = {{(OUT_W+1){1'b0}}, r_amp};
    assign w_prod     = w_ws_ext * w_amp_ext;
    assign w_sc       = w_prod >>> OUT_W;
    assign w_is_const = (r_mode == FG_MODE_CONST) || (r_mode > FG_MODE_NOISE);
    assign w_sum      = w_is_const ? int'($signed(r_offset))
                                   : int'(w_sc) + int'($signed(r_offset));
    assign w_sat      = fg_saturate(w_sum, OUT_W);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending   <= 1'b0;
            r_sh_mode   <= FG_MODE_CONST;
            r_sh_psc    <= '0;
            r_sh_start  <= '0;
            r_sh_stop   <= '0;
            r_sh_inc    <= '0;
            r_sh_duty   <= '0;
            r_sh_amp    <= '0;
            r_sh_offset <= '0;
            r_mode      <= FG_MODE_CONST;
            r_psc       <= '0;
            r_start     <= '0;
            r_stop      <= '0;
            r_inc       <= '0;
            r_duty      <= '0;
            r_amp       <= '0;
            r_offset    <= '0;
            r_psc_cnt   <= '0;
            r_phase     <= '0;
            r_step      <= '0;
            r_lfsr      <= FG_LFSR_SEED;
            r_tick_d    <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_tick_d    <= w_tick;
            r_out_valid <= r_tick_d;
            if (r_tick_d) begin
                r_out <= OUT_W'(w_sat);
            end

            if (w_accept) begin
                r_pending   <= 1'b1;
                r_sh_mode   <= cfg_mode_i;
                r_sh_psc    <= cfg_psc_i;
                r_sh_start  <= cfg_start_i;
                r_sh_stop   <= cfg_stop_i;
                r_sh_inc    <= cfg_inc_i;
                r_sh_duty   <= cfg_duty_i;
                r_sh_amp    <= cfg_amp_i;
                r_sh_offset <= cfg_offset_i;
            end

            if (w_tick) begin
                r_phase <= w_phase_sum[PHASE_W-1:0];
                r_lfsr  <= fg_lfsr_next(r_lfsr);
            end

            if (w_apply) begin
                // Apply replaces this wrap's sweep update; phase keeps its wrapped value
                r_pending <= 1'b0;
                r_mode    <= r_sh_mode;
                r_psc     <= r_sh_psc;
                r_start   <= r_sh_start;
                r_stop    <= r_sh_stop;
                r_inc     <= r_sh_inc;
                r_duty    <= r_sh_duty;
                r_amp     <= r_sh_amp;
                r_offset  <= r_sh_offset;
                r_step    <= r_sh_start;
                r_psc_cnt <= '0;
            end else begin
                if (enable_i) begin
                    r_psc_cnt <= w_tick ? '0 : r_psc_cnt + PSC_W'(1);
                end
                if (w_wrap && (r_inc != '0)) begin
                    if (r_step >= r_stop) begin
                        r_step <= r_start;
                        r_done <= 1'b1;
                    end else begin
                        r_step <= w_step_swept;
                    end
                end
            end
        end
    end

    assign cfg_ready_o  = ~r_pending;
    assign out_o        = r_out;
    assign out_valid_o  = r_out_valid;
    assign sweep_done_o = r_done;

endmodule
